// File: rtl/q02_sweep_ctrl.sv
// Exhaustive 3-input sweep sequencer: drives all 8 {a,b,c} vectors, captures s, checks against EXPECTED.
// Optional build macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module q02_sweep_ctrl #(
   parameter int unsigned SETTLE   = 1,
   parameter logic [7:0]  EXPECTED = 8'h70
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [2:0] abc_out,
   input  logic       s_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] table_out,
   output logic       pass,
   output logic [2:0] fail_idx,
   output logic [3:0] mismatch_cnt
);

   // A SETTLE of 0 behaves as 1, so the last DRIVE count is never below zero.
   localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   state_t     state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [7:0] table_q, table_d;
   logic       pass_q, pass_d;
   logic [2:0] fail_idx_q, fail_idx_d;
   logic [3:0] mismatch_q, mismatch_d;
   logic       mismatch;
   logic       stop_early;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= 3'd0;
         cnt_q      <= 4'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         table_q    <= 8'h00;
         pass_q     <= 1'b0;
         fail_idx_q <= 3'd0;
         mismatch_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         table_q    <= table_d;
         pass_q     <= pass_d;
         fail_idx_q <= fail_idx_d;
         mismatch_q <= mismatch_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      table_d    = table_q;
      pass_d     = pass_q;
      fail_idx_d = fail_idx_q;
      mismatch_d = mismatch_q;
      mismatch   = (s_in != EXPECTED[idx_q]);
`ifdef SWEEP_STOP_ON_FAIL_EN
      stop_early = mismatch;
`else
      stop_early = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = DRIVE;
               idx_d      = 3'd0;
               cnt_d      = 4'd0;
               busy_d     = 1'b1;
               table_d    = 8'h00;
               pass_d     = 1'b0;
               fail_idx_d = 3'd0;
               mismatch_d = 4'd0;
            end
         end
         DRIVE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 4'd0;
               state_d = SAMPLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         SAMPLE: begin
            table_d[idx_q] = s_in;
            if (mismatch) begin
               mismatch_d = mismatch_q + 4'd1;
               if (mismatch_q == 4'd0) begin
                  fail_idx_d = idx_q;
               end
            end
            // The index stops at 7 rather than wrapping, so the sweep always terminates.
            if (idx_q == 3'd7 || stop_early) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = DRIVE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (table_q == EXPECTED);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign abc_out      = idx_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign table_out    = table_q;
   assign pass         = pass_q;
   assign fail_idx     = fail_idx_q;
   assign mismatch_cnt = mismatch_q;

endmodule

// File: tb/tb_q02_sweep_ctrl.sv
// Bench for q02_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driven by table-based s_in models
// and checked cycle by cycle against a sweep model derived from the function s = a&~c | a&~b&c.
module tb_q02_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start1 = 1'b0;
   logic       start3 = 1'b0;
   logic [7:0] tbl1 = 8'h00;
   logic [7:0] tbl3 = 8'h00;
   logic       sel = 1'b0;

   logic [2:0] abc1, abc3;
   logic       s1, s3;
   logic       busy1, busy3, done1, done3, pass1, pass3;
   logic [7:0] table1, table3;
   logic [2:0] fidx1, fidx3;
   logic [3:0] mcnt1, mcnt3;

   logic [2:0] m_abc;
   logic       m_busy, m_done, m_pass;
   logic [7:0] m_table;
   logic [2:0] m_fidx;
   logic [3:0] m_mcnt;

   logic [7:0] gold;
   int         n_cmp = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   // The function block is modelled as a lookup into a per-instance truth table.
   assign s1 = tbl1[abc1];
   assign s3 = tbl3[abc3];

   assign m_abc   = sel ? abc3   : abc1;
   assign m_busy  = sel ? busy3  : busy1;
   assign m_done  = sel ? done3  : done1;
   assign m_pass  = sel ? pass3  : pass1;
   assign m_table = sel ? table3 : table1;
   assign m_fidx  = sel ? fidx3  : fidx1;
   assign m_mcnt  = sel ? mcnt3  : mcnt1;

   q02_sweep_ctrl #(.SETTLE(1), .EXPECTED(8'h70)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abc_out(abc1), .s_in(s1),
      .busy(busy1), .done(done1), .table_out(table1), .pass(pass1),
      .fail_idx(fidx1), .mismatch_cnt(mcnt1)
   );

   q02_sweep_ctrl #(.SETTLE(3), .EXPECTED(8'h70)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .abc_out(abc3), .s_in(s3),
      .busy(busy3), .done(done3), .table_out(table3), .pass(pass3),
      .fail_idx(fidx3), .mismatch_cnt(mcnt3)
   );

   function automatic logic ref_s(input int v);
      logic a, b, c;
      a = v[2];
      b = v[1];
      c = v[0];
      return (a & ~c) | (a & ~b & c);
   endfunction

   task automatic drive_start(input bit use3, input logic v);
      if (use3) start3 = v;
      else      start1 = v;
   endtask

   // One full sweep on the chosen instance, checked on every cycle from acceptance to one cycle past done.
   task automatic run_sweep(input bit use3, input logic [7:0] tbl, input bit spam, input string name);
      int         per, first, cnt, last_v, done_k, exp_abc;
      logic [7:0] exp_tab;
      logic [2:0] exp_fail;
      logic       exp_pass;
      per   = use3 ? 4 : 2;
      first = -1;
      cnt   = 0;
      for (int i = 0; i < 8; i++) begin
         if (tbl[i] != gold[i]) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      last_v = 7;
`ifdef SWEEP_STOP_ON_FAIL_EN
      if (first >= 0) begin
         last_v = first;
         cnt    = 1;
      end
`endif
      exp_tab = 8'h00;
      for (int i = 0; i <= last_v; i++) exp_tab[i] = tbl[i];
      exp_fail = (first < 0) ? 3'd0 : 3'(first);
      exp_pass = (exp_tab == gold);
      done_k   = (last_v + 1) * per + 1;

      sel = use3;
      if (use3) tbl3 = tbl;
      else      tbl1 = tbl;
      @(negedge clk);
      drive_start(use3, 1'b1);
      @(posedge clk);
      #1;
      drive_start(use3, 1'b0);
      for (int k = 0; k <= done_k + 1; k++) begin
         exp_abc = (k / per > last_v) ? last_v : k / per;
         n_cmp += 3;
         if (m_busy !== (k < done_k)) begin
            n_fail++;
            $display("FAIL %s busy k=%0d: got %b want %b", name, k, m_busy, (k < done_k));
         end
         if (m_done !== (k == done_k)) begin
            n_fail++;
            $display("FAIL %s done k=%0d: got %b want %b", name, k, m_done, (k == done_k));
         end
         if (m_abc !== 3'(exp_abc)) begin
            n_fail++;
            $display("FAIL %s abc_out k=%0d: got %0d want %0d", name, k, m_abc, exp_abc);
         end
         if (k == 0) begin
            n_cmp += 3;
            if (m_table !== 8'h00 || m_pass !== 1'b0 || m_mcnt !== 4'd0) begin
               n_fail++;
               $display("FAIL %s clear_on_start: got tbl=%h pass=%b cnt=%0d want 00/0/0", name, m_table, m_pass, m_mcnt);
            end
         end
         if (k >= done_k) begin
            n_cmp += 4;
            if (m_table !== exp_tab) begin
               n_fail++;
               $display("FAIL %s table_out k=%0d: got %h want %h", name, k, m_table, exp_tab);
            end
            if (m_pass !== exp_pass) begin
               n_fail++;
               $display("FAIL %s pass k=%0d: got %b want %b", name, k, m_pass, exp_pass);
            end
            if (m_fidx !== exp_fail) begin
               n_fail++;
               $display("FAIL %s fail_idx k=%0d: got %0d want %0d", name, k, m_fidx, exp_fail);
            end
            if (m_mcnt !== 4'(cnt)) begin
               n_fail++;
               $display("FAIL %s mismatch_cnt k=%0d: got %0d want %0d", name, k, m_mcnt, cnt);
            end
         end
         // Extra starts land on edges where the sweep is still running, so they must be ignored.
         drive_start(use3, (spam && (k == 5 || k == 20) && (k + 1 <= done_k)) ? 1'b1 : 1'b0);
         if (k <= done_k) begin
            @(posedge clk);
            #1;
         end
      end
      drive_start(use3, 1'b0);
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         n_cmp += 7;
         if (m_abc !== 3'd0 || m_busy !== 1'b0 || m_done !== 1'b0 || m_table !== 8'h00 ||
             m_pass !== 1'b0 || m_fidx !== 3'd0 || m_mcnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values inst=%0d: got abc=%0d busy=%b done=%b tbl=%h pass=%b fidx=%0d cnt=%0d want all 0",
                     s, m_abc, m_busy, m_done, m_table, m_pass, m_fidx, m_mcnt);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_correct();
      run_sweep(1'b0, gold, 1'b0, "correct_s1");
   endtask

   task automatic test_stuck0();
      run_sweep(1'b0, 8'h00, 1'b0, "stuck0");
   endtask

   task automatic test_stuck1();
      run_sweep(1'b0, 8'hFF, 1'b0, "stuck1");
   endtask

   task automatic test_settle3_spam();
      run_sweep(1'b1, gold, 1'b1, "settle3_spam");
   endtask

   task automatic test_reset_abort();
      bit found;
      found = 1'b0;
      sel   = 1'b0;
      tbl1  = gold;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (abc1 == 3'd5) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      n_cmp++;
      if (!found) begin
         n_fail++;
         $display("FAIL abort_reach_vec5: got abc=%0d want 5 within 40 cycles", abc1);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp += 7;
      if (abc1 !== 3'd0 || busy1 !== 1'b0 || done1 !== 1'b0 || table1 !== 8'h00 ||
          pass1 !== 1'b0 || fidx1 !== 3'd0 || mcnt1 !== 4'd0) begin
         n_fail++;
         $display("FAIL abort_async_clear: got abc=%0d busy=%b done=%b tbl=%h pass=%b fidx=%0d cnt=%0d want all 0",
                  abc1, busy1, done1, table1, pass1, fidx1, mcnt1);
      end
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            @(negedge clk);
            rst_n = 1'b1;
         end
         @(posedge clk);
         #1;
         n_cmp += 2;
         if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done cyc=%0d: got done=%b busy=%b want 0/0", i, done1, busy1);
         end
      end
      run_sweep(1'b0, gold, 1'b0, "after_abort");
   endtask

   task automatic test_random();
      logic [7:0] t;
      for (int n = 0; n < 8; n++) begin
         t = gold;
         if ($urandom_range(0, 3) != 0) t = gold ^ 8'($urandom);
         run_sweep(1'($urandom_range(0, 1)), t, 1'($urandom_range(0, 1)), $sformatf("random%0d", n));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) gold[i] = ref_s(i);
      test_reset();
      test_correct();
      test_stuck0();
      test_stuck1();
      test_settle3_spam();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
